// File: rtl/leaf_pkg.sv
// Shared definitions for the leaf-shell output path: packet field layout and route-table entry.
package leaf_pkg;

    localparam int LEAF_W    = 5;
    localparam int PORT_W    = 4;
    localparam int ADDR_W    = 7;
    localparam int PAYLOAD_W = 32;

    // Packet layout, MSB to LSB: {valid, leaf, port, addr, payload}
    localparam int PKT_ADDR_LSB = PAYLOAD_W;
    localparam int PKT_PORT_LSB = PKT_ADDR_LSB + ADDR_W;
    localparam int PKT_LEAF_LSB = PKT_PORT_LSB + PORT_W;
    localparam int PKT_VLD_BIT  = PKT_LEAF_LSB + LEAF_W;

    typedef struct packed {
        logic              configured;
        logic [LEAF_W-1:0] leaf;
        logic [PORT_W-1:0] port;
    } route_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the previous winner.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic          found;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = ptr;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PW'(idx);
            end
        end
        grant = '0;
        if (advance && found) begin
            grant[win] = 1'b1;
        end
    end

    // Pointer only moves when a grant is actually issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (win == PW'(N - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Output scheduler for a leaf shell: round-robin over user streams, route stamping,
// per-port credit flow control and a registered packet output toward the BFT.
module leaf_out_arbiter
    import leaf_pkg::*;
#(
    parameter int PACKET_BITS    = 49,
    parameter int PAYLOAD_BITS   = 32,
    parameter int NUM_LEAF_BITS  = 5,
    parameter int NUM_PORT_BITS  = 4,
    parameter int NUM_ADDR_BITS  = 7,
    parameter int NUM_OUT_PORTS  = 3,
    parameter int CREDIT_BITS    = 8,
    parameter int FREESPACE_INIT = 64
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  cfg_we,
    input  logic [$clog2(NUM_OUT_PORTS)-1:0]      cfg_idx,
    input  logic [NUM_LEAF_BITS-1:0]              cfg_leaf,
    input  logic [NUM_PORT_BITS-1:0]              cfg_port,
    input  logic                                  credit_vld,
    input  logic [$clog2(NUM_OUT_PORTS)-1:0]      credit_idx,
    input  logic [CREDIT_BITS-1:0]                credit_amt,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]              vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]              ack_interface2user,
    input  logic                                  bft_ready,
    input  logic                                  resend,
    output logic [PACKET_BITS-1:0]                dout_packet
);

    localparam int IDX_W = $clog2(NUM_OUT_PORTS);

    route_entry_t             route      [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit     [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_nxt [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq        [NUM_OUT_PORTS];

    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] grant;
    logic                     can_issue;
    logic                     any_grant;

    logic [PAYLOAD_BITS-1:0]  win_payload;
    logic [NUM_LEAF_BITS-1:0] win_leaf;
    logic [NUM_PORT_BITS-1:0] win_port;
    logic [NUM_ADDR_BITS-1:0] win_addr;

    logic [PACKET_BITS-1:0]   pkt_q;
    logic [PACKET_BITS-1:0]   pkt_next;

    // Eligibility never looks at payload data, so ack has no path from din.
    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = vld_user2interface[i] && route[i].configured && (credit[i] != '0);
        end
    end

    assign can_issue = !resend && (!pkt_q[PKT_VLD_BIT] || bft_ready);

    rr_arbiter #(
        .N (NUM_OUT_PORTS)
    ) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (eligible),
        .advance (can_issue),
        .grant   (grant)
    );

    assign ack_interface2user = grant;
    assign any_grant          = |grant;

    always_comb begin
        win_payload = '0;
        win_leaf    = '0;
        win_port    = '0;
        win_addr    = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant[i]) begin
                win_payload = win_payload | din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
                win_leaf    = win_leaf | route[i].leaf;
                win_port    = win_port | route[i].port;
                win_addr    = win_addr | seq[i];
            end
        end
    end

    always_comb begin
        pkt_next                                      = '0;
        pkt_next[PKT_VLD_BIT]                         = 1'b1;
        pkt_next[PKT_LEAF_LSB +: NUM_LEAF_BITS]       = win_leaf;
        pkt_next[PKT_PORT_LSB +: NUM_PORT_BITS]       = win_port;
        pkt_next[PKT_ADDR_LSB +: NUM_ADDR_BITS]       = win_addr;
        pkt_next[0 +: PAYLOAD_BITS]                   = win_payload;
    end

    // A write lands at the edge, so a same-cycle grant still stamps the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                route[i] <= '0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    route[i] <= {1'b1, cfg_leaf, cfg_port};
                end
            end
        end
    end

    // Net change of a grant and a freespace update in one step, saturating at the top.
    always_comb begin
        logic [CREDIT_BITS:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            sum = {1'b0, credit[i]}
                + ((credit_vld && (credit_idx == IDX_W'(i))) ? {1'b0, credit_amt} : '0)
                - (CREDIT_BITS + 1)'(grant[i]);
            credit_nxt[i] = sum[CREDIT_BITS] ? '1 : sum[CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (reset) begin
                credit[i] <= CREDIT_BITS'(FREESPACE_INIT);
            end else if (!resend) begin
                credit[i] <= credit_nxt[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (reset) begin
                seq[i] <= '0;
            end else if (grant[i]) begin
                seq[i] <= seq[i] + 1'b1;
            end
        end
    end

    // During resend the held packet is frozen even if the downstream reports ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_q <= '0;
        end else if (any_grant) begin
            pkt_q <= pkt_next;
        end else if (!resend && bft_ready) begin
            pkt_q[PKT_VLD_BIT] <= 1'b0;
        end
    end

    assign dout_packet = resend ? '0 : pkt_q;

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Self-checking bench for leaf_out_arbiter against a cycle-level behavioural model.
module tb_leaf_out_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic [4:0]  cfg_leaf;
    logic [3:0]  cfg_port;
    logic        credit_vld;
    logic [1:0]  credit_idx;
    logic [7:0]  credit_amt;
    logic [31:0] data [3];
    logic [95:0] din;
    logic [2:0]  vld;
    logic [2:0]  ack;
    logic        bft_ready;
    logic        resend;
    logic [48:0] dout;

    int checks = 0;
    int errors = 0;
    bit rand_vld = 1'b0;

    // Behavioural model state
    bit          m_cfg    [3];
    logic [4:0]  m_leaf   [3];
    logic [3:0]  m_port   [3];
    int          m_credit [3];
    int          m_seq    [3];
    int          m_last;
    logic [48:0] m_pkt;
    logic [31:0] sent_q [$];

    assign din = {data[2], data[1], data[0]};

    always #5 clk = ~clk;

    leaf_out_arbiter dut (
        .clk                     (clk),
        .reset                   (reset),
        .cfg_we                  (cfg_we),
        .cfg_idx                 (cfg_idx),
        .cfg_leaf                (cfg_leaf),
        .cfg_port                (cfg_port),
        .credit_vld              (credit_vld),
        .credit_idx              (credit_idx),
        .credit_amt              (credit_amt),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .bft_ready               (bft_ready),
        .resend                  (resend),
        .dout_packet             (dout)
    );

    function automatic logic [2:0] model_ack();
        if (resend || (m_pkt[48] === 1'b1 && !bft_ready)) return 3'b000;
        for (int k = 1; k <= 3; k++) begin
            int p = (m_last + k) % 3;
            if (vld[p] && m_cfg[p] && m_credit[p] > 0) return 3'(1 << p);
        end
        return 3'b000;
    endfunction

    function automatic logic [48:0] model_dout();
        return resend ? 49'd0 : m_pkt;
    endfunction

    task automatic model_update(input logic [2:0] g);
        int w;
        if (reset) begin
            for (int p = 0; p < 3; p++) begin
                m_cfg[p]    = 1'b0;
                m_leaf[p]   = '0;
                m_port[p]   = '0;
                m_credit[p] = 64;
                m_seq[p]    = 0;
            end
            m_last = 2;
            m_pkt  = '0;
            return;
        end
        if (g != 3'b000) begin
            w = g[0] ? 0 : (g[1] ? 1 : 2);
            m_pkt    = {1'b1, m_leaf[w], m_port[w], 7'(m_seq[w]), data[w]};
            m_seq[w] = (m_seq[w] + 1) % 128;
            m_last   = w;
            sent_q.push_back(data[w]);
        end else if (!resend && bft_ready) begin
            m_pkt[48] = 1'b0;
        end
        if (!resend) begin
            for (int p = 0; p < 3; p++) begin
                m_credit[p] += (credit_vld && credit_idx == 2'(p)) ? int'(credit_amt) : 0;
                m_credit[p] -= g[p] ? 1 : 0;
                if (m_credit[p] > 255) m_credit[p] = 255;
            end
        end
        if (cfg_we && cfg_idx < 2'd3) begin
            m_cfg[cfg_idx]  = 1'b1;
            m_leaf[cfg_idx] = cfg_leaf;
            m_port[cfg_idx] = cfg_port;
        end
    endtask

    // A user that was acked presents a fresh payload; in random mode vld also toggles.
    task automatic user_update(input logic [2:0] g);
        for (int p = 0; p < 3; p++) begin
            if (g[p]) begin
                data[p] = $urandom;
                if (rand_vld) vld[p] = 1'($urandom_range(0, 1));
            end else if (rand_vld && !vld[p]) begin
                vld[p] = 1'($urandom_range(0, 1));
            end
        end
    endtask

    task automatic step();
        logic [2:0] g;
        g = model_ack();
        @(posedge clk);
        model_update(g);
        #1;
        user_update(g);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        vld        = 3'b000;
        cfg_we     = 1'b0;
        credit_vld = 1'b0;
        resend     = 1'b0;
        bft_ready  = 1'b1;
        rand_vld   = 1'b0;
        step();
        step();
        reset = 1'b0;
        sent_q.delete();
    endtask

    task automatic configure(input int p, input logic [4:0] leaf, input logic [3:0] port);
        cfg_we   = 1'b1;
        cfg_idx  = 2'(p);
        cfg_leaf = leaf;
        cfg_port = port;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic configure_all();
        configure(0, 5'd1, 4'd3);
        configure(1, 5'd5, 4'd2);
        configure(2, 5'd9, 4'd7);
    endtask

    task automatic test_reset();
        do_reset();
        vld = 3'b111;
        #1;
        checks++;
        if (dout !== 49'd0) begin
            errors++;
            $display("[TB] FAIL reset_dout: got %h expected %h", dout, 49'd0);
        end
        checks++;
        if (ack !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_ack: got %b expected %b", ack, 3'b000);
        end
        vld = 3'b000;
    endtask

    task automatic test_single_packet();
        logic [48:0] exp_pkt;
        configure(1, 5'd5, 4'd2);
        data[1]   = 32'hDEADBEEF;
        vld       = 3'b010;
        bft_ready = 1'b1;
        #1;
        checks++;
        if (ack !== 3'b010) begin
            errors++;
            $display("[TB] FAIL single_ack: got %b expected %b", ack, 3'b010);
        end
        step();
        vld = 3'b000;
        #1;
        exp_pkt = {1'b1, 5'd5, 4'd2, 7'd0, 32'hDEADBEEF};
        checks++;
        if (dout !== exp_pkt) begin
            errors++;
            $display("[TB] FAIL single_dout: got %h expected %h", dout, exp_pkt);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ack;
        do_reset();
        configure_all();
        vld = 3'b111;
        for (int i = 0; i < 6; i++) begin
            #1;
            exp_ack = 3'(1 << (i % 3));
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("[TB] FAIL rr_order[%0d]: got %b expected %b", i, ack, exp_ack);
            end
            checks++;
            if (dout !== model_dout()) begin
                errors++;
                $display("[TB] FAIL rr_dout[%0d]: got %h expected %h", i, dout, model_dout());
            end
            step();
        end
        vld = 3'b000;
    endtask

    task automatic test_credit_exhaust();
        int acks;
        do_reset();
        configure(0, 5'd2, 4'd1);
        vld  = 3'b001;
        acks = 0;
        for (int i = 0; i < 70; i++) begin
            #1;
            checks++;
            if (ack !== model_ack() || dout !== model_dout()) begin
                errors++;
                $display("[TB] FAIL credit_cycle[%0d]: got ack %b dout %h expected ack %b dout %h",
                         i, ack, dout, model_ack(), model_dout());
            end
            if (ack[0] === 1'b1) acks++;
            step();
        end
        checks++;
        if (acks != 64) begin
            errors++;
            $display("[TB] FAIL credit_limit: got %0d acks expected %0d", acks, 64);
        end
        credit_vld = 1'b1;
        credit_idx = 2'd0;
        credit_amt = 8'd4;
        #1;
        checks++;
        if (ack !== 3'b000) begin
            errors++;
            $display("[TB] FAIL credit_update_same_cycle: got %b expected %b", ack, 3'b000);
        end
        step();
        credit_vld = 1'b0;
        acks = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ack[0] === 1'b1) acks++;
            step();
        end
        checks++;
        if (acks != 4) begin
            errors++;
            $display("[TB] FAIL credit_refill: got %0d acks expected %0d", acks, 4);
        end
        vld = 3'b000;
    endtask

    task automatic test_back_to_back();
        logic [48:0] held;
        logic [31:0] exp_data;
        do_reset();
        configure_all();
        held = '0;
        for (int i = 0; i < 33; i++) begin
            if (i == 0)  begin rand_vld = 1'b1; vld = 3'($urandom_range(0, 7)); end
            if (i == 12) begin rand_vld = 1'b0; vld = 3'b111; end
            if (i == 13) begin bft_ready = 1'b0; held = dout; end
            if (i == 18) begin bft_ready = 1'b1; rand_vld = 1'b1; end
            if (i == 30) begin rand_vld = 1'b0; vld = 3'b000; end
            #1;
            checks++;
            if (ack !== model_ack() || dout !== model_dout()) begin
                errors++;
                $display("[TB] FAIL bp_cycle[%0d]: got ack %b dout %h expected ack %b dout %h",
                         i, ack, dout, model_ack(), model_dout());
            end
            if (i >= 13 && i < 18) begin
                checks++;
                if (dout !== held || held[48] !== 1'b1 || ack !== 3'b000) begin
                    errors++;
                    $display("[TB] FAIL bp_hold[%0d]: got dout %h ack %b expected dout %h ack 000",
                             i, dout, ack, held);
                end
            end
            if (dout[48] === 1'b1 && bft_ready) begin
                checks++;
                if (sent_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL bp_stream[%0d]: got payload %h expected none", i, dout[31:0]);
                end else begin
                    exp_data = sent_q.pop_front();
                    if (dout[31:0] !== exp_data) begin
                        errors++;
                        $display("[TB] FAIL bp_stream[%0d]: got payload %h expected %h",
                                 i, dout[31:0], exp_data);
                    end
                end
            end
            step();
        end
        checks++;
        if (sent_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL bp_lost: got %0d undelivered expected 0", sent_q.size());
        end
    endtask

    task automatic test_seq_wrap();
        int acks;
        do_reset();
        configure(2, 5'd3, 4'd1);
        vld        = 3'b100;
        credit_vld = 1'b1;
        credit_idx = 2'd2;
        for (int i = 0; i < 130; i++) begin
            credit_amt = (i == 60) ? 8'd5 : 8'd1;
            #1;
            checks++;
            if (ack !== 3'b100 || dout !== model_dout()) begin
                errors++;
                $display("[TB] FAIL seq_cycle[%0d]: got ack %b dout %h expected ack 100 dout %h",
                         i, ack, dout, model_dout());
            end
            if (i > 0) begin
                checks++;
                if (dout[38:32] !== 7'((i - 1) % 128)) begin
                    errors++;
                    $display("[TB] FAIL seq_addr[%0d]: got %0d expected %0d", i, dout[38:32], (i - 1) % 128);
                end
            end
            step();
        end
        credit_vld = 1'b0;
        #1;
        checks++;
        if (dout[38:32] !== 7'd1) begin
            errors++;
            $display("[TB] FAIL seq_addr_last: got %0d expected %0d", dout[38:32], 1);
        end
        acks = 0;
        for (int i = 0; i < 80; i++) begin
            #1;
            if (ack[2] === 1'b1) acks++;
            step();
        end
        checks++;
        if (acks != 68) begin
            errors++;
            $display("[TB] FAIL seq_net_credit: got %0d acks expected %0d", acks, 68);
        end
        vld = 3'b000;
    endtask

    task automatic test_resend();
        logic [48:0] held;
        do_reset();
        configure_all();
        rand_vld = 1'b1;
        vld      = 3'b101;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (ack !== model_ack() || dout !== model_dout()) begin
                errors++;
                $display("[TB] FAIL resend_pre[%0d]: got ack %b dout %h expected ack %b dout %h",
                         i, ack, dout, model_ack(), model_dout());
            end
            step();
        end
        rand_vld = 1'b0;
        vld      = 3'b111;
        step();
        held   = m_pkt;
        resend = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (dout !== 49'd0 || ack !== 3'b000) begin
                errors++;
                $display("[TB] FAIL resend_hold[%0d]: got dout %h ack %b expected dout 0 ack 000",
                         i, dout, ack);
            end
            step();
        end
        resend = 1'b0;
        #1;
        checks++;
        if (dout !== held || held[48] !== 1'b1) begin
            errors++;
            $display("[TB] FAIL resend_reappear: got %h expected %h", dout, held);
        end
        rand_vld = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (ack !== model_ack() || dout !== model_dout()) begin
                errors++;
                $display("[TB] FAIL resend_post[%0d]: got ack %b dout %h expected ack %b dout %h",
                         i, ack, dout, model_ack(), model_dout());
            end
            step();
        end
        rand_vld = 1'b0;
        vld      = 3'b111;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++;
        if (dout !== 49'd0 || ack !== 3'b000) begin
            errors++;
            $display("[TB] FAIL midstream_reset: got dout %h ack %b expected dout 0 ack 000", dout, ack);
        end
        vld = 3'b000;
    endtask

    initial begin
        reset      = 1'b1;
        cfg_we     = 1'b0;
        cfg_idx    = '0;
        cfg_leaf   = '0;
        cfg_port   = '0;
        credit_vld = 1'b0;
        credit_idx = '0;
        credit_amt = '0;
        vld        = '0;
        bft_ready  = 1'b1;
        resend     = 1'b0;
        for (int p = 0; p < 3; p++) data[p] = $urandom;
        @(negedge clk);
        test_reset();
        test_single_packet();
        test_round_robin();
        test_credit_exhaust();
        test_back_to_back();
        test_seq_wrap();
        test_resend();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/leaf_out_arbiter.md
# leaf_out_arbiter

Output-side scheduler for a leaf shell. It shares the single `PACKET_BITS`-wide leaf-to-BFT output among the `NUM_OUT_PORTS` user output streams using round-robin arbitration. Each accepted payload is stamped with the destination leaf, port and BRAM write address. Per-port credit counters are replenished by freespace updates from the destination, so no destination buffer is ever overrun. The block sits between the user kernel's `din_leaf_user2interface`/`vld`/`ack` ports and the packet output toward the BFT.

## Interface
Parameters:
- `PACKET_BITS`, 49: output packet width; equals 1 + `NUM_LEAF_BITS` + `NUM_PORT_BITS` + `NUM_ADDR_BITS` + `PAYLOAD_BITS`.
- `PAYLOAD_BITS`, 32: user data width.
- `NUM_LEAF_BITS`, 5: destination leaf field width.
- `NUM_PORT_BITS`, 4: destination port field width.
- `NUM_ADDR_BITS`, 7: destination BRAM address field width.
- `NUM_OUT_PORTS`, 3: number of user output streams.
- `CREDIT_BITS`, 8: width of each credit counter.
- `FREESPACE_INIT`, 64: credit value loaded at reset (destination buffer depth).

Ports:
- `clk`, in, 1: single clock for the whole block.
- `reset`, in, 1: synchronous, active-high.
- `cfg_we`, in, 1: write one route-table entry.
- `cfg_idx`, in, `$clog2(NUM_OUT_PORTS)`: index of the entry to write.
- `cfg_leaf`, in, `NUM_LEAF_BITS`: destination leaf for that entry.
- `cfg_port`, in, `NUM_PORT_BITS`: destination port for that entry.
- `credit_vld`, in, 1: freespace update strobe.
- `credit_idx`, in, `$clog2(NUM_OUT_PORTS)`: port the update applies to.
- `credit_amt`, in, `CREDIT_BITS`: credits to add.
- `din_leaf_user2interface`, in, `NUM_OUT_PORTS*PAYLOAD_BITS`: port i occupies slice i.
- `vld_user2interface`, in, `NUM_OUT_PORTS`: per-port data valid.
- `ack_interface2user`, out, `NUM_OUT_PORTS`: per-port accept, one-hot or zero.
- `bft_ready`, in, 1: downstream can take a packet this cycle.
- `resend`, in, 1: freeze request.
- `dout_packet`, out, `PACKET_BITS`: registered packet output.

## Operation
- **Route table.** One entry per port holds {leaf, port, configured bit}; reset clears all entries to unconfigured.
  - `cfg_we` writes the entry and sets its configured bit.
- **Eligibility.** Port i is eligible when `vld[i]`, the configured bit is set, and `credit[i] != 0`.
- **Grant.** A grant is issued when `can_issue` = `!resend && (!dout_packet[PACKET_BITS-1] || bft_ready)` is true and at least one port is eligible.
  - The winner is the first eligible port in round-robin order, starting one past the last winner. The pointer resets to port 0, so port 0 has first priority after reset.
  - `ack_interface2user[i]` is combinational and equals the grant; the payload is consumed at that clock edge.
  - A user holds `vld` and data until it sees `ack`.
- **Packet format.** Bits, MSB to LSB: {valid=1, leaf, port, addr, payload}.
  - `addr` is the per-port sequence counter.
  - Each sequence counter is `NUM_ADDR_BITS` wide, resets to 0, increments on grant, and wraps from 127 to 0.
- **Output register.**
  - On a grant it loads the new packet.
  - When the held packet is taken (`bft_ready`) and there is no new grant, the valid bit clears.
  - When `bft_ready` is low, the packet and its valid bit hold.
- **Credits.** Each counter resets to `FREESPACE_INIT`.
  - A grant subtracts 1; a matching `credit_vld` adds `credit_amt`.
  - Simultaneous grant and update on the same port apply the net change in one cycle.
  - The counter saturates at 2^`CREDIT_BITS`-1.
- **Resend.** While `resend` is high:
  - no grants are issued and all acks are 0;
  - `dout_packet` drives all-zero;
  - internal state (held packet, credits, pointer, counters) holds.
  - When resend falls, the held packet reappears.
- **Reset** takes priority over every other input.

## Timing
- Reset values: `dout_packet` = 0, `ack_interface2user` = 0, credits = `FREESPACE_INIT`, pointer = 0, sequence counters = 0.
- Latency: a payload acked in cycle N appears on `dout_packet` in cycle N+1.
- Throughput: one packet per cycle while `bft_ready` stays high.
- `ack` depends combinationally on `vld_user2interface`, `bft_ready`, `resend` and registered state. There is no combinational path from `din_leaf_user2interface` to `ack`.
- A route-table write takes effect from the next cycle. A grant in the same cycle as a write uses the old entry.
- A credit update is usable for eligibility from the next cycle.

## Structure
- Package `leaf_pkg`:
  - packet field offset and width localparams (`PKT_VLD_BIT`, `PKT_LEAF_LSB`, `PKT_PORT_LSB`, `PKT_ADDR_LSB`);
  - a route-entry typedef.
- Sub-module `rr_arbiter`:
  - parameterised by N;
  - inputs: req vector, advance enable;
  - outputs: one-hot grant, with the pointer held inside the sub-module.
- Credit counters, sequence counters, route table and output register live in `leaf_out_arbiter`.

## Test plan
- Reset, then configure port 1 to leaf 5 / port 2. Drive `vld[1]` with data 0xDEADBEEF and `bft_ready`=1. Required:
  - `ack[1]` is high in cycle N;
  - in cycle N+1, `dout_packet` = {1, 5'd5, 4'd2, 7'd0, 0xDEADBEEF}.
- Configure all three ports and hold `vld`=3'b111. Required: grant order 0, 1, 2, 0, 1, 2, one grant per cycle.
- Send 64 packets on port 0 with no credit updates. Required:
  - the 65th payload is not acked;
  - `credit_vld` with amount 4 on port 0 lets exactly 4 more through.
- Hold `bft_ready`=0 for 5 cycles with the output valid. Required: `dout_packet` is stable and no acks are issued; the stream resumes with no loss or duplication.
- Send 130 packets on port 2. Required: `addr` runs 0..127, 0, 1. Also issue a grant and a credit update on the same port in the same cycle; required: a net +amt-1 change.
- Raise `resend` for 3 cycles mid-stream. Required: `dout_packet` = 0 and acks are 0 throughout; when resend falls, the same held packet reappears. Then assert `reset` mid-stream; required: all outputs return to their reset values on the next edge.
